// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared keyboard constants, channel indices and button FSM states
//
// Purpose : common definitions for the button conditioning stage and the
//           keyboard top level that consumes its outputs.
// Contents: channel index constants, default 100 MHz timing, FSM state enum.
package keyboard_pkg;

   // Channel assignment of the conditioned buttons.
   localparam int BTN_NEXT    = 0;
   localparam int BTN_PREV    = 1;
   localparam int BTN_CONFIRM = 2;
   localparam int BTN_OCT     = 3;

   localparam int N_BTN_DEFAULT = 4;

   // Default timing at 100 MHz: 20 ms debounce, 0.5 s long hold, 0.2 s repeat.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 2_000_000;
   localparam int HOLD_CYCLES_DEFAULT     = 50_000_000;
   localparam int REPEAT_CYCLES_DEFAULT   = 20_000_000;

   typedef enum logic [1:0] {
      RELEASED = 2'd0,
      PRESSED  = 2'd1,
      LONG     = 2'd2
   } btn_state_t;

endpackage

// File: rtl/button_conditioner_if.sv
// rtl/button_conditioner_if.sv - button bundle between raw board inputs and conditioned outputs
//
// Purpose : groups the per-channel button vectors into one port.
// Signals : btn_raw     raw asynchronous buttons (driven by master)
//           repeat_en   per-channel auto-repeat enable (driven by master)
//           btn_level   debounced level (driven by slave)
//           btn_press   one-cycle press / auto-repeat pulse (driven by slave)
//           btn_release one-cycle release pulse (driven by slave)
//           btn_long    long-hold flag (driven by slave)
interface button_conditioner_if #(
   parameter int N_BTN = keyboard_pkg::N_BTN_DEFAULT
);
   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] repeat_en;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] btn_press;
   logic [N_BTN-1:0] btn_release;
   logic [N_BTN-1:0] btn_long;

   modport master (
      output btn_raw,
      output repeat_en,
      input  btn_level,
      input  btn_press,
      input  btn_release,
      input  btn_long
   );

   modport slave (
      input  btn_raw,
      input  repeat_en,
      output btn_level,
      output btn_press,
      output btn_release,
      output btn_long
   );
endinterface

// File: rtl/button_conditioner_channel.sv
// rtl/button_conditioner_channel.sv - one button channel: synchroniser, debounce, hold/repeat FSM
//
// Purpose : conditions a single raw button into a clean level plus
//           press/release pulses, a long-hold flag and auto-repeat pulses.
// Ports   : clk, reset      clock, synchronous active-high reset
//           i_raw           raw asynchronous button
//           i_repeat_en     auto-repeat enable, sampled every cycle
//           o_level         debounced level
//           o_press         press / auto-repeat pulse
//           o_release       release pulse
//           o_long          high while held for at least HOLD_CYCLES
module button_channel
   import keyboard_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic i_raw,
   input  logic i_repeat_en,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_long
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(HOLD_CYCLES + 1);
   localparam int RW = $clog2(REPEAT_CYCLES + 1);

   // Counters act on the "last" value so the event lands on the cycle the
   // count would reach its limit.
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);
   localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic [DW-1:0] r_cnt;
   logic [HW-1:0] r_hold;
   logic [RW-1:0] r_rep;
   btn_state_t    r_state;
   logic          r_level;
   logic          r_press;
   logic          r_release;
   logic          r_long;

   logic          w_accept;
   logic [DW-1:0] w_cnt_nxt;
   logic [HW-1:0] w_hold_nxt;
   logic [RW-1:0] w_rep_nxt;
   btn_state_t    w_state_nxt;
   logic          w_level_nxt;
   logic          w_press_nxt;
   logic          w_release_nxt;
   logic          w_long_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_cnt     <= '0;
         r_hold    <= '0;
         r_rep     <= '0;
         r_state   <= RELEASED;
         r_level   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_long    <= 1'b0;
      end else begin
         r_sync1   <= i_raw;
         r_sync2   <= r_sync1;
         r_cnt     <= w_cnt_nxt;
         r_hold    <= w_hold_nxt;
         r_rep     <= w_rep_nxt;
         r_state   <= w_state_nxt;
         r_level   <= w_level_nxt;
         r_press   <= w_press_nxt;
         r_release <= w_release_nxt;
         r_long    <= w_long_nxt;
      end
   end

   always_comb begin
      w_accept      = 1'b0;
      w_cnt_nxt     = '0;
      w_hold_nxt    = r_hold;
      w_rep_nxt     = r_rep;
      w_state_nxt   = r_state;
      w_press_nxt   = 1'b0;
      w_release_nxt = 1'b0;
      w_long_nxt    = r_long;

      // Debounce: count consecutive disagreeing cycles, any agreement restarts.
      if (r_sync2 != r_level) begin
         if (r_cnt == DEB_LAST) begin
            w_accept = 1'b1;
         end else begin
            w_cnt_nxt = r_cnt + 1'b1;
         end
      end
      w_level_nxt = r_level ^ w_accept;

      // An accepted edge overrides hold/repeat work in the same cycle, so a
      // release can never coincide with a repeat press.
      if (w_accept && r_level) begin
         w_state_nxt   = RELEASED;
         w_release_nxt = 1'b1;
         w_long_nxt    = 1'b0;
      end else if (w_accept) begin
         w_state_nxt = PRESSED;
         w_hold_nxt  = '0;
         w_press_nxt = 1'b1;
      end else begin
         case (r_state)
            PRESSED: begin
               if (r_hold == HOLD_LAST) begin
                  w_hold_nxt  = HOLD_MAX;
                  w_state_nxt = LONG;
                  w_long_nxt  = 1'b1;
                  w_press_nxt = i_repeat_en;
                  w_rep_nxt   = '0;
               end else begin
                  w_hold_nxt = r_hold + 1'b1;
               end
            end
            LONG: begin
               // Repeat phase runs regardless of the enable; it only gates the pulse.
               if (r_rep == REP_LAST) begin
                  w_rep_nxt   = '0;
                  w_press_nxt = i_repeat_en;
               end else begin
                  w_rep_nxt = r_rep + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_long    = r_long;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - N_BTN independent button conditioning channels
//
// Purpose : conditions the raw board buttons for the keyboard top level.
// Ports   : clk    system clock
//           reset  synchronous active-high reset
//           bus    button_conditioner_if slave (raw inputs in, clean outputs out)
module button_conditioner
   import keyboard_pkg::*;
#(
   parameter int N_BTN           = N_BTN_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int HOLD_CYCLES     = HOLD_CYCLES_DEFAULT,
   parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   button_conditioner_if.slave  bus
);

   logic [N_BTN-1:0] w_level;
   logic [N_BTN-1:0] w_press;
   logic [N_BTN-1:0] w_release;
   logic [N_BTN-1:0] w_long;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .HOLD_CYCLES     (HOLD_CYCLES),
         .REPEAT_CYCLES   (REPEAT_CYCLES)
      ) u_channel (
         .clk         (clk),
         .reset       (reset),
         .i_raw       (bus.btn_raw[g]),
         .i_repeat_en (bus.repeat_en[g]),
         .o_level     (w_level[g]),
         .o_press     (w_press[g]),
         .o_release   (w_release[g]),
         .o_long      (w_long[g])
      );
   end

   assign bus.btn_level   = w_level;
   assign bus.btn_press   = w_press;
   assign bus.btn_release = w_release;
   assign bus.btn_long    = w_long;

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed table-driven bench for button_conditioner
module tb_button_conditioner;

   typedef struct {
      int         at;
      logic       rst;
      logic [3:0] raw;
      logic [3:0] ren;
   } stim_t;

   typedef struct {
      int         at;
      logic [3:0] lvl;
      logic [3:0] prs;
      logic [3:0] rel;
      logic [3:0] lng;
   } chk_t;

   logic clk = 1'b0;
   logic reset = 1'b1;

   button_conditioner_if #(.N_BTN(4)) bus ();

   button_conditioner #(
      .N_BTN           (4),
      .DEBOUNCE_CYCLES (4),
      .HOLD_CYCLES     (20),
      .REPEAT_CYCLES   (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   stim_t stim[$];
   chk_t  chk[$];
   int    exp_np[4];
   int    exp_nr[4];

   function automatic void add_s(int at, logic rst, logic [3:0] raw, logic [3:0] ren);
      stim_t s;
      s.at = at; s.rst = rst; s.raw = raw; s.ren = ren;
      stim.push_back(s);
   endfunction

   function automatic void add_c(int at, logic [3:0] lvl, logic [3:0] prs, logic [3:0] rel, logic [3:0] lng);
      chk_t c;
      c.at = at; c.lvl = lvl; c.prs = prs; c.rel = rel; c.lng = lng;
      chk.push_back(c);
   endfunction

   function automatic void set_counts(int p0, int p1, int p2, int p3, int r0, int r1, int r2, int r3);
      exp_np[0] = p0; exp_np[1] = p1; exp_np[2] = p2; exp_np[3] = p3;
      exp_nr[0] = r0; exp_nr[1] = r1; exp_nr[2] = r2; exp_nr[3] = r3;
   endfunction

   task automatic check_vec(string name, int c, logic [3:0] act, logic [3:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s cycle %0d: got %b expected %b", name, c, act, exp);
      end
   endtask

   task automatic check_int(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_stims(int c);
      foreach (stim[i]) begin
         if (stim[i].at == c) begin
            reset         = stim[i].rst;
            bus.btn_raw   = stim[i].raw;
            bus.repeat_en = stim[i].ren;
         end
      end
   endtask

   // Cycle 0 is the period right after the last reset edge; inputs listed for
   // cycle c are driven just after edge c, outputs listed for c are those
   // registered by edge c.
   task automatic run_scn(string name, int ncyc);
      int np[4];
      int nr[4];
      for (int k = 0; k < 4; k++) begin
         np[k] = 0;
         nr[k] = 0;
      end
      reset         = 1'b1;
      bus.btn_raw   = 4'b0000;
      bus.repeat_en = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      check_vec({name, ".reset_level"}, 0, bus.btn_level, 4'b0000);
      check_vec({name, ".reset_press"}, 0, bus.btn_press, 4'b0000);
      check_vec({name, ".reset_release"}, 0, bus.btn_release, 4'b0000);
      check_vec({name, ".reset_long"}, 0, bus.btn_long, 4'b0000);
      apply_stims(0);
      for (int c = 1; c <= ncyc; c++) begin
         @(posedge clk);
         #1;
         for (int k = 0; k < 4; k++) begin
            if (bus.btn_press[k] === 1'b1) np[k]++;
            if (bus.btn_release[k] === 1'b1) nr[k]++;
         end
         foreach (chk[i]) begin
            if (chk[i].at == c) begin
               check_vec({name, ".level"}, c, bus.btn_level, chk[i].lvl);
               check_vec({name, ".press"}, c, bus.btn_press, chk[i].prs);
               check_vec({name, ".release"}, c, bus.btn_release, chk[i].rel);
               check_vec({name, ".long"}, c, bus.btn_long, chk[i].lng);
            end
         end
         apply_stims(c);
      end
      for (int k = 0; k < 4; k++) begin
         check_int($sformatf("%s.press_count[%0d]", name, k), np[k], exp_np[k]);
         check_int($sformatf("%s.release_count[%0d]", name, k), nr[k], exp_nr[k]);
      end
      stim.delete();
      chk.delete();
   endtask

   initial begin
      bus.btn_raw   = 4'b0000;
      bus.repeat_en = 4'b0000;

      // Clean press at 10 then release at 20: edges land 2+4 cycles later.
      add_s(0, 1'b0, 4'b0000, 4'b0011);
      add_s(10, 1'b0, 4'b0001, 4'b0011);
      add_s(20, 1'b0, 4'b0000, 4'b0011);
      add_c(15, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(16, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add_c(17, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add_c(25, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add_c(26, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      add_c(27, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      set_counts(1, 0, 0, 0, 1, 0, 0, 0);
      run_scn("clean", 40);

      // Bounce with 2-cycle runs, stable high from 20.
      add_s(0, 1'b0, 4'b0000, 4'b0011);
      add_s(10, 1'b0, 4'b0001, 4'b0011);
      add_s(12, 1'b0, 4'b0000, 4'b0011);
      add_s(14, 1'b0, 4'b0001, 4'b0011);
      add_s(16, 1'b0, 4'b0000, 4'b0011);
      add_s(20, 1'b0, 4'b0001, 4'b0011);
      add_c(18, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(25, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(26, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add_c(27, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      set_counts(1, 0, 0, 0, 0, 0, 0, 0);
      run_scn("bounce", 35);

      // Long hold with repeat: P=16, long at 36, wraps at 44/52/60/68, release at 72.
      add_s(0, 1'b0, 4'b0000, 4'b0001);
      add_s(10, 1'b0, 4'b0001, 4'b0001);
      add_s(66, 1'b0, 4'b0000, 4'b0001);
      add_c(16, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add_c(35, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add_c(36, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      add_c(37, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add_c(43, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add_c(44, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      add_c(52, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      add_c(60, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      add_c(68, 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      add_c(71, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add_c(72, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      add_c(73, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      set_counts(6, 0, 0, 0, 1, 0, 0, 0);
      run_scn("repeat", 80);

      // Same hold with repeat disabled: only the initial press.
      add_s(0, 1'b0, 4'b0000, 4'b0000);
      add_s(10, 1'b0, 4'b0001, 4'b0000);
      add_s(66, 1'b0, 4'b0000, 4'b0000);
      add_c(16, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add_c(35, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      add_c(36, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add_c(44, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add_c(71, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add_c(72, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
      set_counts(1, 0, 0, 0, 1, 0, 0, 0);
      run_scn("norepeat", 80);

      // One-cycle reset in LONG with button held: fresh press 6 cycles later.
      add_s(0, 1'b0, 4'b0000, 4'b0001);
      add_s(10, 1'b0, 4'b0001, 4'b0001);
      add_s(40, 1'b1, 4'b0001, 4'b0001);
      add_s(41, 1'b0, 4'b0001, 4'b0001);
      add_c(40, 4'b0001, 4'b0000, 4'b0000, 4'b0001);
      add_c(41, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(46, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(47, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
      add_c(48, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
      set_counts(3, 0, 0, 0, 0, 0, 0, 0);
      run_scn("midreset", 60);

      // 3-cycle glitch on channel 2, then channels 1 and 3 pressed together.
      add_s(0, 1'b0, 4'b0000, 4'b0011);
      add_s(10, 1'b0, 4'b0100, 4'b0011);
      add_s(13, 1'b0, 4'b0000, 4'b0011);
      add_s(20, 1'b0, 4'b1010, 4'b0011);
      add_c(15, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(16, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(19, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(25, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
      add_c(26, 4'b1010, 4'b1010, 4'b0000, 4'b0000);
      add_c(27, 4'b1010, 4'b0000, 4'b0000, 4'b0000);
      set_counts(0, 1, 0, 1, 0, 0, 0, 0);
      run_scn("glitch", 40);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
